ysyx_24100005_rf_wb_arbiter: RTL and testbench

//  Shares the register file's single write port among NR_REQ writeback requesters
//  (e.g. ALU, LSU, CSR) with round-robin arbitration and a valid/ready handshake.

---
 rtl/ysyx_24100005_rf_wb_arbiter_if.sv | 31 +++
 rtl/ysyx_24100005_rf_wb_arbiter.sv | 101 ++++++++++
 tb/tb_ysyx_24100005_rf_wb_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24100005_rf_wb_arbiter_if.sv
// Writeback/dispatch/decode bundle between the requesters and the RF write-port arbiter.
// The master side drives requests and decode queries; the slave side is the arbiter.
interface ysyx_24100005_rf_wb_arbiter_if #(
    parameter int NR_REQ     = 3,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic [NR_REQ-1:0]            req_valid;
    logic [NR_REQ-1:0]            req_ready;
    logic [NR_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NR_REQ*DATA_WIDTH-1:0] req_data;
    logic                         issue_valid;
    logic [ADDR_WIDTH-1:0]        issue_addr;
    logic [ADDR_WIDTH-1:0]        rs1addr;
    logic [ADDR_WIDTH-1:0]        rs2addr;
    logic                         rs1_busy;
    logic                         rs2_busy;
    logic                         rf_wen;
    logic [ADDR_WIDTH-1:0]        rf_waddr;
    logic [DATA_WIDTH-1:0]        rf_wdata;

    modport master (
        output req_valid, req_addr, req_data, issue_valid, issue_addr, rs1addr, rs2addr,
        input  req_ready, rs1_busy, rs2_busy, rf_wen, rf_waddr, rf_wdata
    );

    modport slave (
        input  req_valid, req_addr, req_data, issue_valid, issue_addr, rs1addr, rs2addr,
        output req_ready, rs1_busy, rs2_busy, rf_wen, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/ysyx_24100005_rf_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among NR_REQ writeback
// requesters, with a per-register busy scoreboard for decode RAW-hazard stalls.
module ysyx_24100005_rf_wb_arbiter #(
    parameter int NR_REQ     = 3,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic clk,
    input  logic rst_n,
    ysyx_24100005_rf_wb_arbiter_if.slave bus
);
    localparam int PTR_W   = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
    localparam int NR_REGS = 1 << ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] addr_arr [NR_REQ];
    logic [DATA_WIDTH-1:0] data_arr [NR_REQ];

    generate
        for (genvar gi = 0; gi < NR_REQ; gi++) begin : g_slice
            assign addr_arr[gi] = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign data_arr[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [NR_REGS-1:0]    busy_q, busy_d;
    logic                  rf_wen_q;
    logic [ADDR_WIDTH-1:0] rf_waddr_q;
    logic [DATA_WIDTH-1:0] rf_wdata_q;

    logic                  found;
    logic [PTR_W-1:0]      win_idx;
    logic [NR_REQ-1:0]     grant;
    logic                  transfer;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_data;
    int                    idx;

    // Scan from ptr upward, wrapping at NR_REQ; first valid requester wins.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int k = 0; k < NR_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NR_REQ) idx = idx - NR_REQ;
            if (!found && bus.req_valid[idx]) begin
                found   = 1'b1;
                win_idx = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        grant = '0;
        if (found && rst_n) grant[win_idx] = 1'b1;
    end

    assign transfer      = found && rst_n;
    assign win_addr      = addr_arr[win_idx];
    assign win_data      = data_arr[win_idx];
    assign bus.req_ready = grant;

    always_comb begin
        ptr_d = ptr_q;
        if (transfer) ptr_d = (win_idx == PTR_W'(NR_REQ - 1)) ? '0 : win_idx + 1'b1;
    end

    // Set is applied after clear so a same-edge reissue marks the new producer busy.
    always_comb begin
        busy_d = busy_q;
        if (rf_wen_q) busy_d[rf_waddr_q] = 1'b0;
        if (bus.issue_valid && (bus.issue_addr != '0)) busy_d[bus.issue_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            busy_q     <= '0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            ptr_q    <= ptr_d;
            busy_q   <= busy_d;
            rf_wen_q <= transfer && (win_addr != '0);
            if (transfer) begin
                rf_waddr_q <= win_addr;
                rf_wdata_q <= win_data;
            end
        end
    end

    assign bus.rf_wen   = rf_wen_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.rs1_busy = rst_n && busy_q[bus.rs1addr];
    assign bus.rs2_busy = rst_n && busy_q[bus.rs2addr];

endmodule

// File: tb/tb_ysyx_24100005_rf_wb_arbiter.sv
// Directed bench: expected RF writes are queued at grant time and matched by a monitor.
module tb_ysyx_24100005_rf_wb_arbiter;
    logic clk;
    logic rst_n;

    ysyx_24100005_rf_wb_arbiter_if #(.NR_REQ(3), .ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

    ysyx_24100005_rf_wb_arbiter #(.NR_REQ(3), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t  exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic [31:0] tb_busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        bus.req_addr[i*5 +: 5]  = a;
        bus.req_data[i*32 +: 32] = d;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_q.push_back(w);
    endtask

    task automatic issue(input logic [4:0] a);
        if (a != 0 && tb_busy[a] && !(bus.rf_wen && bus.rf_waddr == a)) begin
            errors++;
            $display("FAIL issue_to_busy: reg %0d still pending", a);
        end
        bus.issue_valid = 1'b1;
        bus.issue_addr  = a;
        if (a != 0) tb_busy[a] = 1'b1;
    endtask

    // Monitor: every RF write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && bus.rf_wen) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected none", bus.rf_waddr, bus.rf_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                $display("write addr=%0d data=%08h (expected addr=%0d data=%08h)", bus.rf_waddr, bus.rf_wdata, e.a, e.d);
                chk("wr_addr", 64'(bus.rf_waddr), 64'(e.a));
                chk("wr_data", 64'(bus.rf_wdata), 64'(e.d));
                tb_busy[e.a] = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    logic [2:0]  rr_exp  [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [4:0]  rr_addr [6] = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
    logic [31:0] rr_data [6] = '{32'hA0, 32'hA1, 32'hA2, 32'hA0, 32'hA1, 32'hA2};

    initial begin
        tb_busy         = '0;
        rst_n           = 1'b0;
        bus.req_valid   = '0;
        bus.req_addr    = '0;
        bus.req_data    = '0;
        bus.issue_valid = 1'b0;
        bus.issue_addr  = '0;
        bus.rs1addr     = '0;
        bus.rs2addr     = '0;
        repeat (2) @(negedge clk);
        chk("reset_ready", 64'(bus.req_ready), 64'd0);
        chk("reset_wen", 64'(bus.rf_wen), 64'd0);
        chk("reset_waddr", 64'(bus.rf_waddr), 64'd0);
        chk("reset_wdata", 64'(bus.rf_wdata), 64'd0);

        // Round robin with all three requesters valid.
        @(negedge clk);
        rst_n = 1'b1;
        set_req(0, 5'd1, 32'hA0);
        set_req(1, 5'd2, 32'hA1);
        set_req(2, 5'd3, 32'hA2);
        bus.req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            chk("rr_grant", 64'(bus.req_ready), 64'(rr_exp[c]));
            push(rr_addr[c], rr_data[c]);
        end
        @(negedge clk);
        bus.req_valid = '0;

        // Latency: one write visible for exactly one cycle.
        @(negedge clk);
        set_req(0, 5'd5, 32'hDEADBEEF);
        bus.req_valid = 3'b001;
        #1 chk("lat_grant", 64'(bus.req_ready), 64'b001);
        push(5'd5, 32'hDEADBEEF);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        #1 chk("lat_wen_drop", 64'(bus.rf_wen), 64'd0);

        // Scoreboard set at issue, held through commit cycle, cleared after.
        @(negedge clk);
        issue(5'd7);
        bus.rs1addr = 5'd7;
        #1 chk("sb_before_issue", 64'(bus.rs1_busy), 64'd0);
        @(negedge clk);
        bus.issue_valid = 1'b0;
        #1 chk("sb_busy", 64'(bus.rs1_busy), 64'd1);
        set_req(1, 5'd7, 32'h77);
        bus.req_valid = 3'b010;
        #1 chk("sb_grant", 64'(bus.req_ready), 64'b010);
        push(5'd7, 32'h77);
        @(negedge clk);
        bus.req_valid = '0;
        #1 chk("sb_commit_cycle", 64'(bus.rs1_busy), 64'd1);
        @(negedge clk);
        #1 chk("sb_cleared", 64'(bus.rs1_busy), 64'd0);

        // Register 0: handshake completes, no write, never busy.
        @(negedge clk);
        set_req(2, 5'd0, 32'h55);
        bus.req_valid = 3'b100;
        #1 chk("x0_grant", 64'(bus.req_ready), 64'b100);
        @(negedge clk);
        bus.req_valid = '0;
        #1 chk("x0_wen", 64'(bus.rf_wen), 64'd0);
        issue(5'd0);
        bus.rs2addr = 5'd0;
        @(negedge clk);
        bus.issue_valid = 1'b0;
        #1 chk("x0_busy", 64'(bus.rs2_busy), 64'd0);

        // Same-edge commit and reissue of reg 9: set wins.
        @(negedge clk);
        issue(5'd9);
        bus.rs1addr = 5'd9;
        @(negedge clk);
        bus.issue_valid = 1'b0;
        set_req(0, 5'd9, 32'h99);
        bus.req_valid = 3'b001;
        #1 chk("same_grant", 64'(bus.req_ready), 64'b001);
        push(5'd9, 32'h99);
        @(negedge clk);
        bus.req_valid = '0;
        issue(5'd9);
        #1 chk("same_commit_busy", 64'(bus.rs1_busy), 64'd1);
        @(negedge clk);
        bus.issue_valid = 1'b0;
        #1 chk("same_set_wins", 64'(bus.rs1_busy), 64'd1);
        set_req(1, 5'd9, 32'h9A);
        bus.req_valid = 3'b010;
        #1 chk("same_grant2", 64'(bus.req_ready), 64'b010);
        push(5'd9, 32'h9A);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        #1 chk("same_cleared", 64'(bus.rs1_busy), 64'd0);

        // Reset mid-run with all requesters valid.
        @(negedge clk);
        issue(5'd12);
        bus.rs2addr = 5'd12;
        @(negedge clk);
        bus.issue_valid = 1'b0;
        #1 chk("rst_pre_busy", 64'(bus.rs2_busy), 64'd1);
        set_req(0, 5'd1, 32'hB0);
        set_req(1, 5'd2, 32'hB1);
        set_req(2, 5'd3, 32'hB2);
        bus.req_valid = 3'b111;
        #1 chk("rst_pre_grant", 64'(bus.req_ready), 64'b100);
        push(5'd3, 32'hB2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        tb_busy = '0;
        #1;
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_wen", 64'(bus.rf_wen), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_ptr_zero", 64'(bus.req_ready), 64'b001);
        chk("rst_busy_cleared", 64'(bus.rs2_busy), 64'd0);
        push(5'd1, 32'hB0);
        @(negedge clk);
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
